// File: rtl/pov_pkg.sv
// pov_pkg: shared constants, types and the swap-FSM encoding for the
// persistence-of-vision framebuffer arbiter.
package pov_pkg;

    localparam int ROWS_DEF = 52;    // LEDs on the strip
    localparam int COLS_DEF = 64;    // angular columns per revolution
    localparam int FB_DEPTH = 4096;  // pixels per bank
    localparam int PIX_W    = 24;    // GRB pixel width
    localparam int FB_AW    = 12;    // linear pixel address width
    localparam int IDX_W    = 6;     // row / column / theta index width

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [FB_AW-1:0] fb_addr_t;
    typedef logic [IDX_W-1:0] idx_t;

    // RUN: front bank fixed; PENDING: swap armed, waiting for theta wrap.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_t;

    // Row-major linear pixel address: row*cols + col.
    function automatic fb_addr_t lin_addr(input idx_t row, input idx_t col, input int cols);
        return FB_AW'(row) * FB_AW'(cols) + FB_AW'(col);
    endfunction

endpackage

// File: rtl/pov_fb_arbiter_if.sv
// pov_fb_arbiter_if: display fetch, CPU access, swap control and RAM port
// of the framebuffer arbiter. slave = arbiter side, master = the rest.
interface pov_fb_arbiter_if;
    import pov_pkg::*;

    // Angle / swap control
    idx_t             theta;
    logic             swap_req;
    logic             swap_pending;
    logic             front_sel;

    // Display fetch
    logic             disp_req;
    idx_t             disp_row;
    idx_t             disp_col;
    pixel_t           disp_data;
    logic             disp_valid;

    // CPU access
    logic             cpu_req;
    logic             cpu_we;
    fb_addr_t         cpu_addr;
    pixel_t           cpu_wdata;
    logic             cpu_ack;
    pixel_t           cpu_rdata;

    // Single-port framebuffer RAM, bit FB_AW selects the bank
    logic             mem_we;
    logic [FB_AW:0]   mem_addr;
    pixel_t           mem_wdata;
    pixel_t           mem_rdata;

    modport slave (
        input  theta, swap_req,
        output swap_pending, front_sel,
        input  disp_req, disp_row, disp_col,
        output disp_data, disp_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output theta, swap_req,
        input  swap_pending, front_sel,
        output disp_req, disp_row, disp_col,
        input  disp_data, disp_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/pov_swap_ctrl.sv
// pov_swap_ctrl: revolution-boundary detector and front/back bank swap FSM.
// Build option POV_DBUF_EN enables double buffering; without it the display
// bank is fixed at 0 and swap requests are ignored.
module pov_swap_ctrl
    import pov_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  idx_t theta,
    input  logic swap_req,
    output logic swap_pending,
    output logic front_sel
);

`ifdef POV_DBUF_EN

    localparam idx_t THETA_LAST = IDX_W'(COLS - 1);

    idx_t        theta_q;
    logic        boundary;
    swap_state_t state;

    // Boundary is the single cycle where theta wraps from the last column to 0.
    assign boundary = (theta == '0) && (theta_q == THETA_LAST);

    // Remember last cycle's theta so the wrap can be seen.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            theta_q <= '0;
        end else begin
            theta_q <= theta;
        end
    end

    // Swap FSM: arm on swap_req, toggle the front bank on the next boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (swap_req) begin
                        if (boundary) begin
                            // Request landing on the wrap itself swaps right away.
                            front_sel <= ~front_sel;
                        end else begin
                            state        <= ST_PENDING;
                            swap_pending <= 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    // Further swap_req pulses are ignored here: one toggle only.
                    if (boundary) begin
                        front_sel    <= ~front_sel;
                        state        <= ST_RUN;
                        swap_pending <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    swap_pending <= 1'b0;
                end
            endcase
        end
    end

`else

    // Single bank: display and CPU share bank 0, nothing to swap.
    logic unused_swap_in;
    assign unused_swap_in = ^{clk, reset, theta, swap_req};

    assign swap_pending = 1'b0;
    assign front_sel    = 1'b0;

`endif

endmodule

// File: rtl/pov_fb_arbiter.sv
// pov_fb_arbiter: shares one single-port framebuffer RAM between the LED
// display fetch (fixed priority) and the CPU, with a 2-stage return pipeline.
// Build option POV_DBUF_EN: CPU works on the back bank and the banks swap at
// the revolution boundary; otherwise a single bank is shared.
module pov_fb_arbiter
    import pov_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pov_fb_arbiter_if.slave   bus
);

    localparam logic [IDX_W:0] ROW_LIM = (IDX_W + 1)'(ROWS);
    localparam logic [IDX_W:0] COL_LIM = (IDX_W + 1)'(COLS);
    localparam logic [FB_AW:0] PIX_LIM = (FB_AW + 1)'(ROWS * COLS);

    // Bank control
    logic           front_sel;
    logic           swap_pending;
    logic           cpu_bank;

    // Request decode
    logic           disp_in_range;
    fb_addr_t       disp_lin;
    logic           cpu_in_range;
    logic           cpu_busy;
    logic           cpu_grant;

    // RAM port
    logic           mem_we;
    logic [FB_AW:0] mem_addr;
    pixel_t         mem_wdata;

    // Return pipeline: stage 1 waits for RAM data, stage 2 is the output
    logic           s1_disp_v;
    logic           s1_disp_rd;
    logic           s1_cpu_v;
    logic           s1_cpu_rd;
    logic           disp_valid_q;
    pixel_t         disp_data_q;
    logic           cpu_ack_q;
    pixel_t         cpu_rdata_q;

    pov_swap_ctrl #(
        .COLS         (COLS)
    ) u_swap_ctrl (
        .clk          (clk),
        .reset        (reset),
        .theta        (bus.theta),
        .swap_req     (bus.swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel)
    );

`ifdef POV_DBUF_EN
    // CPU always edits the bank that is not on display.
    assign cpu_bank = ~front_sel;
`else
    // Single bank: front_sel is tied low, so the CPU edits the shown bank.
    assign cpu_bank = front_sel;
`endif

    assign disp_in_range = ({1'b0, bus.disp_row} < ROW_LIM) &&
                           ({1'b0, bus.disp_col} < COL_LIM);
    assign disp_lin      = lin_addr(bus.disp_row, bus.disp_col, COLS);
    assign cpu_in_range  = ({1'b0, bus.cpu_addr} < PIX_LIM);

    // A CPU access is in flight from grant until its ack cycle.
    assign cpu_busy  = s1_cpu_v | cpu_ack_q;
    assign cpu_grant = ~reset & bus.cpu_req & ~bus.disp_req & ~cpu_busy;

    // Drive the RAM port in the request cycle; display wins, out-of-range
    // requests leave the port idle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (bus.disp_req) begin
                if (disp_in_range) begin
                    mem_addr = {front_sel, disp_lin};
                end
            end else if (cpu_grant && cpu_in_range) begin
                mem_addr  = {cpu_bank, bus.cpu_addr};
                mem_we    = bus.cpu_we;
                mem_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
            end
        end
    end

    // Return pipeline: tag the issued access, capture RAM data a cycle later.
    always_ff @(posedge clk) begin
        // NOTE: only control/pipeline state is reset; the framebuffer lives in
        // the external RAM and keeps its contents across reset.
        if (reset) begin
            s1_disp_v    <= 1'b0;
            s1_disp_rd   <= 1'b0;
            s1_cpu_v     <= 1'b0;
            s1_cpu_rd    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            s1_disp_v    <= bus.disp_req;
            s1_disp_rd   <= bus.disp_req & disp_in_range;
            s1_cpu_v     <= cpu_grant;
            s1_cpu_rd    <= cpu_grant & cpu_in_range & ~bus.cpu_we;
            disp_valid_q <= s1_disp_v;
            disp_data_q  <= s1_disp_rd ? bus.mem_rdata : '0;
            cpu_ack_q    <= s1_cpu_v;
            cpu_rdata_q  <= s1_cpu_rd ? bus.mem_rdata : '0;
        end
    end

    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_data    = disp_data_q;
    assign bus.cpu_ack      = cpu_ack_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.swap_pending = swap_pending;
    assign bus.front_sel    = front_sel;

endmodule

// File: tb/tb_pov_fb_arbiter.sv
// tb_pov_fb_arbiter: scoreboard bench for pov_fb_arbiter with a behavioural
// 1-cycle-latency RAM. Works with and without POV_DBUF_EN.
module tb_pov_fb_arbiter;

    localparam int ROWS = 52;
    localparam int COLS = 64;
`ifdef POV_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    typedef struct {
        logic [23:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int   n_checks = 0;
    int   n_pass   = 0;

    exp_t disp_q[$];
    exp_t cpu_q[$];

    logic [23:0] ram    [0:8191];
    logic [23:0] ref_fb [0:8191];
    bit          exp_front = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pov_fb_arbiter_if bus ();

    pov_fb_arbiter #(
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural framebuffer RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [23:0] pat(input int i);
        return 24'hA50000 ^ 24'(i * 7 + 1);
    endfunction

    function automatic bit cpu_bank();
        return DBUF ? ~exp_front : 1'b0;
    endfunction

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_fetch(input int row, input int col, output logic [12:0] addr);
        exp_t e;
        int   lin;
        bus.disp_req = 1'b1;
        bus.disp_row = 6'(row);
        bus.disp_col = 6'(col);
        lin = row * COLS + col;
        if (row < ROWS && col < COLS) begin
            addr   = {exp_front, lin[11:0]};
            e.data = ref_fb[addr];
        end else begin
            addr   = '0;
            e.data = '0;
        end
        e.cyc      = cyc + 2;
        e.chk_data = 1'b1;
        disp_q.push_back(e);
    endtask

    task automatic cpu_start(input bit we, input int addr, input logic [23:0] wd, input int ack_cyc);
        exp_t        e;
        logic [12:0] a;
        a             = {cpu_bank(), 12'(addr)};
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = 12'(addr);
        bus.cpu_wdata = wd;
        e.data        = '0;
        e.chk_data    = !we;
        if (addr < ROWS * COLS) begin
            if (we) ref_fb[a] = wd;
            else    e.data    = ref_fb[a];
        end
        e.cyc = ack_cyc;
        cpu_q.push_back(e);
    endtask

    // Wait (bounded) for cpu_ack, then release the request.
    task automatic cpu_wait();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.cpu_ack && k < 30);
        if (!bus.cpu_ack) check("cpu_ack_timeout", bus.cpu_ack, 1'b1);
        tick();
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_disp_valid"},   bus.disp_valid,   '0);
        check({pfx, "_disp_data"},    bus.disp_data,    '0);
        check({pfx, "_cpu_ack"},      bus.cpu_ack,      '0);
        check({pfx, "_cpu_rdata"},    bus.cpu_rdata,    '0);
        check({pfx, "_mem_we"},       bus.mem_we,       '0);
        check({pfx, "_mem_addr"},     bus.mem_addr,     '0);
        check({pfx, "_mem_wdata"},    bus.mem_wdata,    '0);
        check({pfx, "_swap_pending"}, bus.swap_pending, '0);
        check({pfx, "_front_sel"},    bus.front_sel,    '0);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (bus.disp_valid) begin
                if (disp_q.size() == 0) begin
                    check("disp_valid_unexpected", bus.disp_valid, 1'b0);
                end else begin
                    e = disp_q.pop_front();
                    check("disp_data", bus.disp_data, e.data);
                    check("disp_cycle", cyc, e.cyc);
                end
            end
            if (bus.cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_ack_unexpected", bus.cpu_ack, 1'b0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.chk_data) check("cpu_rdata", bus.cpu_rdata, e.data);
                    check("cpu_ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [12:0] a;
        int          n;

        bus.theta     = '0;
        bus.swap_req  = 1'b0;
        bus.disp_req  = 1'b0;
        bus.disp_row  = '0;
        bus.disp_col  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 8192; i++) begin
            ram[i]    = pat(i);
            ref_fb[i] = pat(i);
        end
        ram[13'h00C5]    = 24'h00FF00;
        ref_fb[13'h00C5] = 24'h00FF00;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");

        // First cycle out of reset: display read row 3 col 5 -> 0x0C5
        tick();
        reset = 1'b0;
        disp_fetch(3, 5, a);
        @(negedge clk);
        check("disp_addr", bus.mem_addr, 13'h00C5);
        check("disp_we", bus.mem_we, 1'b0);
        tick();
        bus.disp_req = 1'b0;
        repeat (3) tick();

        // Collision: display and CPU write in the same cycle
        n = cyc;
        disp_fetch(1, 2, a);
        cpu_start(1'b1, 12'h010, 24'h123456, n + 3);
        @(negedge clk);
        check("coll_disp_addr", bus.mem_addr, a);
        check("coll_disp_we", bus.mem_we, 1'b0);
        tick();
        bus.disp_req = 1'b0;
        @(negedge clk);
        check("coll_cpu_we", bus.mem_we, 1'b1);
        check("coll_cpu_addr", bus.mem_addr, {cpu_bank(), 12'h010});
        check("coll_cpu_wdata", bus.mem_wdata, 24'h123456);
        cpu_wait();

        // Read back the written pixel
        n = cyc;
        cpu_start(1'b0, 12'h010, '0, n + 2);
        @(negedge clk);
        check("rd_addr", bus.mem_addr, {cpu_bank(), 12'h010});
        check("rd_we", bus.mem_we, 1'b0);
        cpu_wait();

        // Out-of-range CPU read and write
        n = cyc;
        cpu_start(1'b0, 12'hD00, '0, n + 2);
        @(negedge clk);
        check("oor_rd_we", bus.mem_we, 1'b0);
        cpu_wait();
        n = cyc;
        cpu_start(1'b1, 12'hD00, 24'hABCDEF, n + 2);
        @(negedge clk);
        check("oor_wr_we", bus.mem_we, 1'b0);
        cpu_wait();
        check("oor_wr_dropped", ram[{cpu_bank(), 12'hD00}], pat({19'd0, cpu_bank(), 12'hD00}));

        // Out-of-range display row
        disp_fetch(52, 0, a);
        @(negedge clk);
        check("oor_disp_we", bus.mem_we, 1'b0);
        tick();
        bus.disp_req = 1'b0;
        repeat (2) tick();

        // Spaced display reads at random in-range positions
        for (int i = 0; i < 6; i++) begin
            disp_fetch(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)), a);
            tick();
            bus.disp_req = 1'b0;
            tick();
        end
        repeat (2) tick();

        // Back-to-back display keeps the CPU waiting
        n = cyc;
        cpu_start(1'b0, 12'h123, '0, n + 8);
        for (int k = 0; k < 6; k++) begin
            disp_fetch(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)), a);
            @(negedge clk);
            check("b2b_disp_addr", bus.mem_addr, a);
            tick();
        end
        bus.disp_req = 1'b0;
        cpu_wait();
        repeat (2) tick();

        // Swap armed away from the boundary, second request while pending
        bus.theta    = 6'd20;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        @(negedge clk);
        check("swap_pending_set", bus.swap_pending, DBUF);
        check("swap_front_hold", bus.front_sel, 1'b0);
        tick();
        bus.theta    = 6'd40;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bus.theta    = 6'd63;
        @(negedge clk);
        check("swap_pending_63", bus.swap_pending, DBUF);
        check("swap_front_63", bus.front_sel, 1'b0);
        tick();
        bus.theta = 6'd0;
        tick();
        @(negedge clk);
        check("swap_front_toggled", bus.front_sel, DBUF);
        check("swap_pending_clr", bus.swap_pending, 1'b0);
        exp_front = DBUF;
        // Another wrap with no request: no second toggle
        tick();
        bus.theta = 6'd63;
        tick();
        bus.theta = 6'd0;
        tick();
        @(negedge clk);
        check("swap_single_toggle", bus.front_sel, DBUF);

        // Display now reads from the new front bank
        tick();
        disp_fetch(3, 5, a);
        @(negedge clk);
        check("front_disp_addr", bus.mem_addr, a);
        tick();
        bus.disp_req = 1'b0;
        repeat (2) tick();

        // Swap request on the boundary cycle, fetch in flight across the swap
        bus.theta = 6'd63;
        tick();
        bus.theta    = 6'd0;
        bus.swap_req = 1'b1;
        disp_fetch(3, 5, a);
        tick();
        bus.swap_req = 1'b0;
        bus.disp_req = 1'b0;
        exp_front    = exp_front ^ DBUF;
        @(negedge clk);
        check("bnd_swap_front", bus.front_sel, exp_front);
        check("bnd_swap_pending", bus.swap_pending, 1'b0);
        repeat (3) tick();

        // Reset asserted in the CPU grant cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 12'h010;
        reset        = 1'b1;
        tick();
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        exp_front   = 1'b0;
        @(negedge clk);
        check_all_zero("rst_grant");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_grant_no_ack", bus.cpu_ack, 1'b0);
        end

        // Display fetch in flight when reset hits
        tick();
        bus.disp_req = 1'b1;
        bus.disp_row = 6'd3;
        bus.disp_col = 6'd5;
        tick();
        bus.disp_req = 1'b0;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_disp_no_valid", bus.disp_valid, 1'b0);
        end

        // CPU access in flight when reset hits, new request right after
        tick();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 12'h010;
        tick();
        bus.cpu_req = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        n     = cyc;
        cpu_start(1'b0, 12'h010, '0, n + 2);
        cpu_wait();
        repeat (4) tick();

        check("disp_sb_empty", disp_q.size(), 0);
        check("cpu_sb_empty", cpu_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pov_fb_arbiter.md
POV_FB_ARBITER -- requirements
Module: pov_fb_arbiter

Interface
REQ-001 Parameter ROWS, default 52, LED rows per column (one per strip LED).
REQ-002 Parameter COLS, default 64, angular columns per revolution (theta range).
REQ-003 clk  input  1  system clock, 100 MHz; the block uses this one clock only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 theta  input  6  current angular column from the break-beam angle generator.
REQ-006 disp_req  input  1  display fetch strobe from the strip controller.
REQ-007 disp_row  input  6  LED index of the fetch.
REQ-008 disp_col  input  6  column of the fetch.
REQ-009 disp_data  output  24  fetched GRB pixel.
REQ-010 disp_valid  output  1  one-cycle pulse qualifying disp_data.
REQ-011 cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-012 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-013 cpu_addr  input  12  linear pixel address, row*COLS+col.
REQ-014 cpu_wdata  input  24  write pixel.
REQ-015 cpu_ack  output  1  one-cycle completion pulse.
REQ-016 cpu_rdata  output  24  read pixel, valid with cpu_ack.
REQ-017 swap_req  input  1  CPU "frame complete" pulse.
REQ-018 swap_pending  output  1  a swap is armed and waiting for the revolution boundary.
REQ-019 front_sel  output  1  bank currently shown on the display.
REQ-020 mem_we, mem_addr[12:0], mem_wdata[24], mem_rdata[24]  output/output/output/input  single-port framebuffer RAM port with 1-cycle read latency; mem_addr[12] is the bank bit.

Function
REQ-021 The RAM port is issued at most one access per cycle; display has fixed priority over CPU.
REQ-022 A disp_req in cycle n drives mem_addr = {front_sel, disp_row*COLS+disp_col} in cycle n; disp_valid and disp_data are asserted in cycle n+2.
REQ-023 A cpu_req is granted in the first cycle with no disp_req and no CPU access already in flight; cpu_ack is asserted 2 cycles after the grant.
REQ-024 CPU accesses always target bank ~front_sel (the back bank) and use the bank value latched at grant.
REQ-025 Display fetches with disp_row >= ROWS or disp_col >= COLS issue no RAM access and return disp_data = 0 with normal latency.
REQ-026 CPU accesses with cpu_addr >= ROWS*COLS issue no RAM access; the write is dropped, the read returns 0, and cpu_ack is still produced with normal latency.
REQ-027 The swap FSM has two states, RUN and PENDING; in RUN, swap_req moves the FSM to PENDING.
REQ-028 A revolution boundary is the cycle where theta == 0 and the previous-cycle theta == COLS-1.
REQ-029 In PENDING, at a boundary front_sel toggles, the FSM returns to RUN, and swap_pending drops in the same cycle.
REQ-030 A swap_req arriving in the boundary cycle while in RUN takes effect in that same boundary.
REQ-031 A swap_req while in PENDING is ignored, with no double toggle.
REQ-032 Fetches already in flight complete from the bank latched at issue, across a swap.
REQ-033 With disp_req back-to-back every cycle, the CPU waits indefinitely; no starvation override is applied.

Reset
REQ-034 Reset clears the following to 0: disp_valid, disp_data, cpu_ack, cpu_rdata, mem_we, mem_addr, mem_wdata, swap_pending, front_sel; the swap FSM goes to RUN.
REQ-035 Accesses in flight when reset asserts are discarded: no valid or ack pulse appears after reset.
REQ-036 Requests are accepted from the first cycle after reset deasserts.
REQ-037 Framebuffer contents are not cleared by reset.

Configuration
REQ-038 Macro POV_DBUF_EN defined: double buffering and swap behave as in REQ-024 and REQ-027 to REQ-032.
REQ-039 Macro POV_DBUF_EN undefined: single bank; mem_addr[12] = 0, front_sel = 0, swap_pending = 0, swap_req ignored, and the CPU writes the displayed bank directly.

Structure
REQ-040 Shared package pov_pkg holds ROWS/COLS defaults, FB_DEPTH = 4096, PIX_W = 24, FB_AW = 12, and the swap-FSM state encoding.
REQ-041 The swap FSM and boundary detector form one sub-module, pov_swap_ctrl; arbitration and the 2-stage return pipeline stay in pov_fb_arbiter.

Verification
REQ-042 Display read: disp_req with row 3, col 5, mem_rdata = 0x00FF00 -> mem_addr 0x0C5 in cycle n, disp_valid with 0x00FF00 in cycle n+2.
REQ-043 Collision: disp_req and a CPU write (addr 0x010, data 0x123456) in the same cycle -> display issued first, CPU write issued at n+1 to bank 1, cpu_ack at n+3.
REQ-044 Out of range: cpu_addr 0xD00 read -> no mem access, cpu_ack with cpu_rdata 0; disp_row 52 -> disp_data 0.
REQ-045 Swap: swap_req with theta = 20, then theta steps 63 -> 0 -> front_sel 0 -> 1 at the theta = 0 cycle, swap_pending low; a second swap_req while pending gives only one toggle.
REQ-046 Reset mid-access: reset asserted at the CPU grant cycle -> no cpu_ack ever, all outputs 0 the next cycle; with POV_DBUF_EN undefined, swap_req leaves front_sel at 0.
